// File: rtl/snac_pkg.sv
// snac_pkg: shared types and constants for the SNAC DB15 joystick sequencer.
//   snac_state_t         : sequencer states
//   SNAC_BITS_PER_PLAYER : buttons per player on the chain
//   SNAC_MAX_BITS        : longest chain (two players)
//   SNAC_LOAD_TICKS      : ticks joy_load_n is held low
package snac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE,
        GAP
    } snac_state_t;

    localparam int unsigned SNAC_BITS_PER_PLAYER = 12;
    localparam int unsigned SNAC_MAX_BITS        = 24;
    localparam int unsigned SNAC_LOAD_TICKS      = 2;

    // Index of the last chain bit for the latched player count.
    function automatic logic [4:0] snac_last_bit(input logic two_players);
        return two_players ? 5'(SNAC_MAX_BITS - 1) : 5'(SNAC_BITS_PER_PLAYER - 1);
    endfunction

endpackage

// File: rtl/snac_db15_ctrl_if.sv
// snac_db15_ctrl_if: serial bus to the external 74HC165-style chain.
//   joy_clk    : shift clock to the chain (driven by the sequencer)
//   joy_load_n : parallel-load strobe, active-low (driven by the sequencer)
//   joy_data   : serial chain output, low = pressed (driven by the chain)
// Modports: master = sequencer side, slave = chain side.
interface snac_db15_ctrl_if;

    logic joy_clk;
    logic joy_load_n;
    logic joy_data;

    modport master (
        output joy_clk,
        output joy_load_n,
        input  joy_data
    );

    modport slave (
        input  joy_clk,
        input  joy_load_n,
        output joy_data
    );

endinterface

// File: rtl/snac_tick_gen.sv
// snac_tick_gen: free-running divider producing a one-cycle tick.
//   clk    : clock
//   rst_n  : asynchronous active-low reset (counter returns to 0)
//   o_tick : high for one cycle when the counter is at DIV-1
module snac_tick_gen #(
    parameter int unsigned DIV = 48
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign o_tick = w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/snac_db15_ctrl.sv
// snac_db15_ctrl: sequencer for the SNAC DB15 serial joystick adapter.
// Loads the external shift-register chain, shifts 12 or 24 bits and publishes
// frame-atomic, active-high button words.
//   clk_sys     : sole clock
//   reset_n     : asynchronous active-low reset
//   enable      : 0 parks the bus and clears the outputs
//   players     : 0 = P1 only (12 bits), 1 = P1+P2 (24 bits); latched at LOAD
//   joy         : serial chain bus (master modport)
//   joystick1   : P1 buttons, active-high
//   joystick2   : P2 buttons, active-high (0 in one-player frames)
//   frame_valid : one-cycle pulse per completed frame
// Optional feature: define SNAC_DB15_DEBOUNCE_EN to update the outputs only
// when two consecutive frames capture the same word.
module snac_db15_ctrl
    import snac_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 48,
    parameter int unsigned FRAME_GAP = 64
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    players,
    snac_db15_ctrl_if.master        joy,
    output logic [11:0]             joystick1,
    output logic [11:0]             joystick2,
    output logic                    frame_valid
);

    localparam int unsigned GW = $clog2(FRAME_GAP + 1);

    logic                      w_tick;
    snac_state_t               r_state;
    logic [1:0]                r_load_cnt;
    logic [GW-1:0]             r_gap_cnt;
    logic [4:0]                r_bit;
    logic                      r_phase;
    logic                      r_two;
    logic [SNAC_MAX_BITS-1:0]  r_shreg;
    logic                      r_jclk;
    logic                      r_load_n;
    logic [11:0]               r_joy1;
    logic [11:0]               r_joy2;
    logic                      r_fv;
    logic [4:0]                w_last;
    logic [SNAC_MAX_BITS-1:0]  w_word;
`ifdef SNAC_DB15_DEBOUNCE_EN
    logic [SNAC_MAX_BITS-1:0]  r_prev;
`endif

    snac_tick_gen #(
        .DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk_sys),
        .rst_n  (reset_n),
        .o_tick (w_tick)
    );

    assign w_last = snac_last_bit(r_two);

    // Active-high frame word; P2 half forced to 0 for one-player frames so
    // stale upper bits from an earlier 24-bit frame never leak out.
    assign w_word = {r_two ? ~r_shreg[SNAC_MAX_BITS-1:SNAC_BITS_PER_PLAYER] : 12'h000,
                     ~r_shreg[SNAC_BITS_PER_PLAYER-1:0]};

    assign joy.joy_clk    = r_jclk;
    assign joy.joy_load_n = r_load_n;
    assign joystick1      = r_joy1;
    assign joystick2      = r_joy2;
    assign frame_valid    = r_fv;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_load_cnt <= '0;
            r_gap_cnt  <= '0;
            r_bit      <= '0;
            r_phase    <= 1'b0;
            r_two      <= 1'b0;
            r_shreg    <= '1;
            r_jclk     <= 1'b0;
            r_load_n   <= 1'b1;
            r_joy1     <= '0;
            r_joy2     <= '0;
            r_fv       <= 1'b0;
`ifdef SNAC_DB15_DEBOUNCE_EN
            r_prev     <= '0;
`endif
        end else if (!enable) begin
            // Park: any partial frame is dropped without a frame_valid.
            r_state    <= IDLE;
            r_load_cnt <= '0;
            r_gap_cnt  <= '0;
            r_bit      <= '0;
            r_phase    <= 1'b0;
            r_jclk     <= 1'b0;
            r_load_n   <= 1'b1;
            r_joy1     <= '0;
            r_joy2     <= '0;
            r_fv       <= 1'b0;
`ifdef SNAC_DB15_DEBOUNCE_EN
            r_prev     <= '0;
`endif
        end else begin
            r_fv <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_tick) begin
                        r_state    <= LOAD;
                        r_load_n   <= 1'b0;
                        r_load_cnt <= '0;
                        r_two      <= players;
                    end
                end
                LOAD: begin
                    if (w_tick) begin
                        if (r_load_cnt == 2'(SNAC_LOAD_TICKS - 1)) begin
                            r_load_n <= 1'b1;
                            r_bit    <= '0;
                            r_phase  <= 1'b0;
                            r_state  <= SHIFT;
                        end else begin
                            r_load_cnt <= r_load_cnt + 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (!r_phase) begin
                            r_shreg[r_bit] <= joy.joy_data;
                            r_jclk         <= 1'b1;
                            r_phase        <= 1'b1;
                        end else begin
                            r_jclk  <= 1'b0;
                            r_phase <= 1'b0;
                            if (r_bit == w_last) begin
                                r_state <= DONE;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    // The final bit was captured on the last even-phase tick,
                    // so the whole word is ready in this single cycle.
`ifdef SNAC_DB15_DEBOUNCE_EN
                    r_prev <= w_word;
                    if (w_word == r_prev) begin
                        r_joy1 <= w_word[11:0];
                        r_joy2 <= w_word[23:12];
                    end
`else
                    r_joy1 <= w_word[11:0];
                    r_joy2 <= w_word[23:12];
`endif
                    r_fv      <= 1'b1;
                    r_gap_cnt <= '0;
                    r_state   <= GAP;
                end
                GAP: begin
                    if (w_tick) begin
                        if (r_gap_cnt == GW'(FRAME_GAP - 1)) begin
                            r_state    <= LOAD;
                            r_load_n   <= 1'b0;
                            r_load_cnt <= '0;
                            r_two      <= players;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
